// File: rtl/vdp_bus_sync.sv
// -----------------------------------------------------------------------------
// vdp_bus_sync
//
// Front end of the VDP that sits directly upstream of the register interface.
// The Z8S180 I/O strobes reach us with no timing relationship to the pixel
// clock. They are synchronized and glitch-filtered here. Every CPU access then
// becomes exactly one single-cycle wr_tick or rd_tick. The write data and the
// port select are held until the next qualified access.
//
// Ports
//   clk         in   pixel clock
//   reset       in   asynchronous reset, active low
//   cpu_iorq_n  in   CPU I/O request (async, active low)
//   cpu_ce_n    in   decoded VDP chip select (async, active low)
//   cpu_rd_n    in   CPU read strobe (async, active low)
//   cpu_wr_n    in   CPU write strobe (async, active low)
//   cpu_a0      in   CPU address bit 0 (0 = VRAM data, 1 = register/status)
//   cpu_din     in   CPU data bus, write direction
//   wr_tick     out  one-clock write pulse
//   rd_tick     out  one-clock read pulse
//   mode        out  cpu_a0 captured when an access qualifies
//   dout        out  cpu_din captured when a write qualifies
//   bus_oe      out  enable for driving VDP read data onto the CPU bus
//   collision   out  sticky flag, set when rd and wr are seen together
//
// Parameters
//   SYNC_STAGES  flops per strobe synchronizer chain (2..4)
//   FILTER       consecutive synchronized clocks a level must hold (1..7)
// -----------------------------------------------------------------------------
module vdp_bus_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_iorq_n,
   input  logic       cpu_ce_n,
   input  logic       cpu_rd_n,
   input  logic       cpu_wr_n,
   input  logic       cpu_a0,
   input  logic [7:0] cpu_din,
   output logic       wr_tick,
   output logic       rd_tick,
   output logic       mode,
   output logic [7:0] dout,
   output logic       bus_oe,
   output logic       collision
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_HOLD = 2'd1,
      ST_RD_HOLD = 2'd2,
      ST_BAD     = 2'd3
   } state_t;

   // A run of FILTER clocks is complete when the condition holds again
   // while the counter already shows FILTER-1.
   localparam logic [2:0] C_FILT    = 3'(FILTER);
   localparam logic [2:0] C_FILT_M1 = 3'(FILTER - 1);

   // Saturating increment of the filter counter
   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      logic [2:0] r;
      if (v >= C_FILT) begin
         r = C_FILT;
      end else begin
         r = v + 3'd1;
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // Strobe synchronizers. The flops reset to 1, the inactive level. Address
   // and data are not synchronized: they are sampled only on the
   // qualification edge, and by then the bus has long been stable.
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_iorq_sync;
   logic [SYNC_STAGES-1:0] r_ce_sync;
   logic [SYNC_STAGES-1:0] r_rd_sync;
   logic [SYNC_STAGES-1:0] r_wr_sync;

   // Shift each raw strobe through its own synchronizer chain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_iorq_sync <= {SYNC_STAGES{1'b1}};
         r_ce_sync   <= {SYNC_STAGES{1'b1}};
         r_rd_sync   <= {SYNC_STAGES{1'b1}};
         r_wr_sync   <= {SYNC_STAGES{1'b1}};
      end else begin
         r_iorq_sync <= {r_iorq_sync[SYNC_STAGES-2:0], cpu_iorq_n};
         r_ce_sync   <= {r_ce_sync[SYNC_STAGES-2:0],   cpu_ce_n};
         r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0],   cpu_rd_n};
         r_wr_sync   <= {r_wr_sync[SYNC_STAGES-2:0],   cpu_wr_n};
      end
   end

   logic w_iorq_s;
   logic w_ce_s;
   logic w_rd_s;
   logic w_wr_s;
   logic w_sel;
   logic w_wr_req;
   logic w_rd_req;

   assign w_iorq_s = r_iorq_sync[SYNC_STAGES-1];
   assign w_ce_s   = r_ce_sync[SYNC_STAGES-1];
   assign w_rd_s   = r_rd_sync[SYNC_STAGES-1];
   assign w_wr_s   = r_wr_sync[SYNC_STAGES-1];
   assign w_sel    = ~w_iorq_s & ~w_ce_s;
   assign w_wr_req = w_sel & ~w_wr_s;
   assign w_rd_req = w_sel & ~w_rd_s;

   // ---------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------
   state_t     r_state;
   logic [2:0] r_cnt;
   // In IDLE one counter serves both the write-only and the read-only
   // condition, so we remember which of the two it is counting. A switch
   // from one to the other starts a fresh run.
   logic       r_kind_wr;
   logic       r_wr_tick;
   logic       r_rd_tick;
   logic       r_mode;
   logic [7:0] r_dout;
   logic       r_collision;

   state_t     w_state_nxt;
   logic [2:0] w_cnt_nxt;
   logic       w_kind_nxt;
   logic       w_wr_tick_nxt;
   logic       w_rd_tick_nxt;
   logic       w_mode_nxt;
   logic [7:0] w_dout_nxt;
   logic       w_coll_nxt;
   logic [2:0] w_run_wr;
   logic [2:0] w_run_rd;
   logic       w_rel_cond;

   // Counter value carried into this clock for each IDLE condition
   always_comb begin
      w_run_wr = 3'd0;
      w_run_rd = 3'd0;
      if (r_kind_wr) begin
         w_run_wr = r_cnt;
      end else begin
         w_run_rd = r_cnt;
      end
   end

   // Release condition for the current hold state
   always_comb begin
      w_rel_cond = 1'b0;
      case (r_state)
         ST_WR_HOLD: w_rel_cond = ~w_wr_req;
         ST_RD_HOLD: w_rel_cond = ~w_rd_req;
         ST_BAD:     w_rel_cond = ~w_wr_req & ~w_rd_req;
         default:    w_rel_cond = 1'b0;
      endcase
   end

   // Next-state, filter counter and output update logic
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_kind_nxt    = r_kind_wr;
      w_wr_tick_nxt = 1'b0;
      w_rd_tick_nxt = 1'b0;
      w_mode_nxt    = r_mode;
      w_dout_nxt    = r_dout;
      w_coll_nxt    = r_collision;

      case (r_state)
         ST_IDLE: begin
            if (w_wr_req && w_rd_req) begin
               // Both strobes together is an illegal bus cycle. Park it in
               // BAD without a tick.
               w_state_nxt = ST_BAD;
               w_coll_nxt  = 1'b1;
               w_cnt_nxt   = 3'd0;
            end else if (w_wr_req) begin
               w_kind_nxt = 1'b1;
               if (w_run_wr == C_FILT_M1) begin
                  w_state_nxt   = ST_WR_HOLD;
                  w_cnt_nxt     = 3'd0;
                  w_wr_tick_nxt = 1'b1;
                  w_dout_nxt    = cpu_din;
                  w_mode_nxt    = cpu_a0;
               end else begin
                  w_cnt_nxt = sat_inc(w_run_wr);
               end
            end else if (w_rd_req) begin
               w_kind_nxt = 1'b0;
               if (w_run_rd == C_FILT_M1) begin
                  w_state_nxt   = ST_RD_HOLD;
                  w_cnt_nxt     = 3'd0;
                  w_rd_tick_nxt = 1'b1;
                  w_mode_nxt    = cpu_a0;
               end else begin
                  w_cnt_nxt = sat_inc(w_run_rd);
               end
            end else begin
               w_cnt_nxt = 3'd0;
            end
         end
         ST_WR_HOLD, ST_RD_HOLD, ST_BAD: begin
            // A request that comes back inside the release window clears the
            // run. The state is held, so no second tick can come out.
            if (w_rel_cond) begin
               if (r_cnt == C_FILT_M1) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = 3'd0;
               end else begin
                  w_cnt_nxt = sat_inc(r_cnt);
               end
            end else begin
               w_cnt_nxt = 3'd0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
         end
      endcase
   end

   // State, counter and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 3'd0;
         r_kind_wr   <= 1'b0;
         r_wr_tick   <= 1'b0;
         r_rd_tick   <= 1'b0;
         r_mode      <= 1'b0;
         r_dout      <= 8'h00;
         r_collision <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_kind_wr   <= w_kind_nxt;
         r_wr_tick   <= w_wr_tick_nxt;
         r_rd_tick   <= w_rd_tick_nxt;
         r_mode      <= w_mode_nxt;
         r_dout      <= w_dout_nxt;
         r_collision <= w_coll_nxt;
      end
   end

   assign wr_tick   = r_wr_tick;
   assign rd_tick   = r_rd_tick;
   assign mode      = r_mode;
   assign dout      = r_dout;
   assign collision = r_collision;

   // The raw strobes gate the output enable directly. The bus is then
   // released the moment the CPU ends the read, not a synchronizer delay
   // later.
   assign bus_oe = (r_state == ST_RD_HOLD) & ~cpu_rd_n & ~cpu_iorq_n & ~cpu_ce_n;

endmodule
